// File: rtl/unidad_pkg.sv
// unidad_pkg: shared types and constants for the unidad_control microsequencer.
// The PAUSE state exists only when UC_SINGLE_STEP_EN is defined.
package unidad_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ALU  = 4'h1,
        OP_SHF  = 4'h2,
        OP_LDI  = 4'h3,
        OP_OUT  = 4'h4,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_JC   = 4'hA,
        OP_JN   = 4'hB,
        OP_JV   = 4'hC,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
`ifdef UC_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_e;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] d;
        logic       we;
        logic       mb;
        logic [3:0] alu;
        logic [1:0] sh;
        logic       mf;
        logic       md;
    } control_t;

    localparam logic [3:0]  ALU_PASS_A = 4'h0;
    localparam int          FLAG_C     = 0;
    localparam int          FLAG_Z     = 1;
    localparam int          FLAG_N     = 2;
    localparam int          FLAG_V     = 3;
    localparam logic [15:0] CTRL_IDLE  = 16'h0000;

endpackage

// File: rtl/decodificador_instr.sv
// decodificador_instr: combinational decode of one 16-bit instruction into a
// datapath control word, immediate and jump/flag qualifiers.
module decodificador_instr
    import unidad_pkg::*;
(
    input  logic [15:0] instr,
    output control_t    ctrl,
    output logic [3:0]  datain,
    output logic        is_jump,
    output logic [3:0]  jump_cond,
    output logic [7:0]  jump_target,
    output logic        writes_flags,
    output logic        is_out,
    output logic        is_halt
);

    assign jump_target = instr[7:0];

    // jump_cond is a mask over {V,N,Z,C}; an empty mask means unconditional
    always_comb begin
        ctrl         = '0;
        datain       = 4'h0;
        is_jump      = 1'b0;
        jump_cond    = 4'h0;
        writes_flags = 1'b0;
        is_out       = 1'b0;
        is_halt      = 1'b0;
        case (instr[15:12])
            OP_ALU: begin
                ctrl.a       = instr[9:8];
                ctrl.b       = instr[7:6];
                ctrl.d       = instr[11:10];
                ctrl.we      = 1'b1;
                ctrl.alu     = instr[3:0];
                writes_flags = 1'b1;
            end
            OP_SHF: begin
                ctrl.a       = instr[9:8];
                ctrl.d       = instr[11:10];
                ctrl.we      = 1'b1;
                ctrl.mf      = 1'b1;
                ctrl.sh      = instr[1:0];
                ctrl.alu     = ALU_PASS_A;
                writes_flags = 1'b1;
            end
            OP_LDI: begin
                ctrl.d  = instr[11:10];
                ctrl.we = 1'b1;
                ctrl.md = 1'b1;
                datain  = instr[3:0];
            end
            OP_OUT: begin
                ctrl.b = instr[7:6];
                ctrl.mb = 1'b1;
                is_out = 1'b1;
            end
            OP_JMP: is_jump = 1'b1;
            OP_JZ: begin
                is_jump           = 1'b1;
                jump_cond[FLAG_Z] = 1'b1;
            end
            OP_JC: begin
                is_jump           = 1'b1;
                jump_cond[FLAG_C] = 1'b1;
            end
            OP_JN: begin
                is_jump           = 1'b1;
                jump_cond[FLAG_N] = 1'b1;
            end
            OP_JV: begin
                is_jump           = 1'b1;
                jump_cond[FLAG_V] = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/unidad_control.sv
// unidad_control: FETCH/DECODE/EXEC microsequencer feeding unidad_procesadora.
// Define UC_SINGLE_STEP_EN to add the step input and the PAUSE state.
module unidad_control
    import unidad_pkg::*;
#(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] instr_addr,
    input  logic [15:0]     instr,
    input  logic [3:0]      flags,
    output logic [15:0]     control,
    output logic [3:0]      datain_out,
    output logic            out_valid,
    output logic            busy,
    output logic            halted
`ifdef UC_SINGLE_STEP_EN
    ,
    input  logic            step
`endif
);

`ifdef UC_SINGLE_STEP_EN
    localparam state_e AFTER_EXEC = S_PAUSE;
`else
    localparam state_e AFTER_EXEC = S_FETCH;
`endif

    state_e          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [3:0]      flag_reg, flag_n;
    logic [15:0]     instr_reg, instr_n;
    control_t        dec_ctrl;
    logic [3:0]      dec_datain;
    logic            is_jump, writes_flags, is_out, is_halt, taken, exec;
    logic [3:0]      jump_cond;
    logic [7:0]      jump_target;

    decodificador_instr u_dec (
        .instr       (instr_reg),
        .ctrl        (dec_ctrl),
        .datain      (dec_datain),
        .is_jump     (is_jump),
        .jump_cond   (jump_cond),
        .jump_target (jump_target),
        .writes_flags(writes_flags),
        .is_out      (is_out),
        .is_halt     (is_halt)
    );

    // outputs decode straight from state so an async reset drops the write at once
    assign exec       = state == S_EXEC;
    assign taken      = is_jump && (jump_cond == 4'h0 || |(jump_cond & flag_reg));
    assign instr_addr = pc;
    assign control    = exec ? dec_ctrl : CTRL_IDLE;
    assign datain_out = exec ? dec_datain : 4'h0;
    assign out_valid  = exec && is_out;
    assign busy       = state == S_FETCH || state == S_DECODE || state == S_EXEC;
    assign halted     = state == S_HALT;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        flag_n  = flag_reg;
        instr_n = instr_reg;
        case (state)
            S_IDLE, S_HALT: begin
                state_n = start ? S_FETCH : state;
                pc_n    = start ? '0 : pc;
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                state_n = S_EXEC;
                instr_n = instr;
            end
            S_EXEC: begin
                state_n = is_halt ? S_HALT : AFTER_EXEC;
                pc_n    = taken ? PC_W'(jump_target) : pc + PC_W'(1);
                flag_n  = writes_flags ? flags : flag_reg;
            end
`ifdef UC_SINGLE_STEP_EN
            S_PAUSE: begin
                state_n = (start || step) ? S_FETCH : S_PAUSE;
                pc_n    = start ? '0 : pc;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            flag_reg  <= 4'h0;
            instr_reg <= 16'h0000;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            flag_reg  <= flag_n;
            instr_reg <= instr_n;
        end
    end

endmodule

// File: doc/unidad_control.md
Name: unidad_control

Overview:
- Microsequencer driving the 16-bit control word and 4-bit data input of unidad_procesadora.
- Fetches 16-bit instructions from an external synchronous program ROM (1-cycle read latency) and decodes each one into a control word.
- Latches the datapath flags and resolves conditional jumps.
- Sits between the program ROM and the datapath; the datapath is no longer driven by hand-built control words.

Parameters:
PC_W, 4, program counter / ROM address width (1..8); PC wraps modulo 2**PC_W.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; starts execution from PC=0 when in IDLE or HALT
instr_addr  out  PC_W  program ROM address
instr  in  16  ROM data, valid one cycle after instr_addr
flags  in  4  datapath flags {V,N,Z,C}, valid during EXEC
control  out  16  {A[15:14],B[13:12],D[11:10],WE[9],MB[8],ALU[7:4],SH[3:2],MF[1],MD[0]}
datain_out  out  4  immediate to datapath datain
out_valid  out  1  one-cycle strobe: datapath dataout holds an OUT result
busy  out  1  high in FETCH/DECODE/EXEC
halted  out  1  high in HALT

Behaviour:
- Reset values (asynchronous, effective immediately):
  - state=IDLE, PC=0, instr_addr=0, control=16'h0000, datain_out=0, out_valid=0, flag_reg=0, busy=0, halted=0.
- Instruction format: op[15:12], rd[11:10], ra[9:8], rb[7:6], fn[5:0]; jump target = instr[7:0] truncated to PC_W.
- FSM:
  - IDLE: start -> FETCH.
  - FETCH: instr_addr=PC -> DECODE.
  - DECODE: register instr -> EXEC.
  - EXEC: drive decoded control word for exactly one cycle; the datapath writes on the closing edge. Then -> FETCH, or -> HALT on op=F.
  - HALT: start -> FETCH with PC=0.
- Throughput: 3 cycles per instruction.
- control=0 and datain_out=0 in every state except EXEC, so no spurious writes occur.
- start is ignored while busy.
- Opcodes:
  - 0 NOP: control=0, PC+1.
  - 1 ALU: A=ra, B=rb, D=rd, WE=1, ALU=fn[3:0], MB=MF=MD=0.
  - 2 SHF: A=ra, D=rd, WE=1, MF=1, SH=fn[1:0], ALU=ALU_PASS_A.
  - 3 LDI: D=rd, WE=1, MD=1, datain_out=fn[3:0].
  - 4 OUT: A=0, B=rb, MB=1, WE=0; out_valid=1 during EXEC.
  - 8 JMP: PC=target.
  - 9 JZ, A JC, B JN, C JV: PC=target if the selected flag_reg bit is 1, else PC+1.
  - F HALT.
  - All other opcodes: NOP.
- Flags:
  - flag_reg <= flags at the end of EXEC for ALU and SHF only.
  - Conditional jumps test flag_reg, i.e. the flags of the most recent ALU/SHF, not the live flags.
- PC:
  - PC+1 wraps from 2**PC_W-1 to 0.
  - A jump to the current PC is legal (infinite loop).
- Reset asserted mid-EXEC forces control to 0 asynchronously; the write being driven is abandoned.

Optional Feature:
- UC_SINGLE_STEP_EN defined:
  - Adds input step (1 bit) and a PAUSE state.
  - After each EXEC the FSM enters PAUSE; busy=0 in PAUSE.
  - A step pulse moves PAUSE -> FETCH.
  - start in PAUSE restarts from PC=0.
  - HALT still goes to HALT directly.
- Undefined: no step port, no PAUSE state, free-running.

Decomposition:
- Package unidad_pkg holds:
  - opcode enum (op_e);
  - state enum (state_e);
  - packed struct control_t matching the control field order;
  - constants ALU_PASS_A, FLAG_V/N/Z/C bit indices, CTRL_IDLE=16'h0000.
- Sub-module decodificador_instr: purely combinational; maps instr to control_t, datain_out, is_jump, jump_cond, writes_flags.
- unidad_control keeps the FSM, PC and flag_reg.

Test Plan:
- Reset: hold rst_n=0 mid-EXEC of ALU -> control=0, busy=0, instr_addr=0 in the same cycle; no datapath write.
- Program LDI r1,5; LDI r2,3; ALU r3=r1+r2; OUT r3; HALT -> out_valid one cycle with dataout=8, halted=1 after 15 cycles from start.
- LDI r1,0; ALU r1=r1-r1 (Z=1); JZ 7 -> next instr_addr=7; repeat with result 1 -> next instr_addr=PC+1.
- ALU sets C=1, then LDI r0,2, then JC 0 -> jump taken, because LDI leaves flag_reg unchanged.
- PC_W=4, NOP at address 15 -> next fetch address 0; opcode 6 behaves as NOP with control=0.
- UC_SINGLE_STEP_EN: no step for 10 cycles -> PAUSE held, control=0; one step pulse -> exactly one instruction executes.
